// File: rtl/mux_nto1_rr.sv
// N-input, W-bit multiplexer with a registered, handshaked output. Selection is
// either a software-steered fixed index or round-robin over requesting channels.
module mux_nto1_rr #(
  parameter int N = 8,
  parameter int W = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N*W-1:0]         in_data,
  input  logic [N-1:0]           in_valid,
  output logic [N-1:0]           in_ready,
  input  logic                   mode,
  input  logic [$clog2(N)-1:0]   sel,
  output logic [W-1:0]           out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [$clog2(N)-1:0]   out_chan
);

  localparam int SEL_W = $clog2(N);

  typedef enum logic {
    MODE_FIXED = 1'b0,
    MODE_RR    = 1'b1
  } mode_e;

  logic [SEL_W-1:0] ptr;
  logic [SEL_W-1:0] grant_idx;
  logic [SEL_W-1:0] rr_idx;
  logic             grant_valid;
  logic             load_en;
  logic             xfer;
  logic [N-1:0]     grant;
  logic [W-1:0]     grant_data;

  // NOTE: every always_comb output gets a default before any branch so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    rr_idx      = '0;
    if (mode_e'(mode) == MODE_FIXED) begin
      // An out-of-range sel simply matches no channel, so nothing is granted.
      for (int i = 0; i < N; i++) begin
        if (sel == SEL_W'(i) && in_valid[i]) begin
          grant_valid = 1'b1;
          grant_idx   = SEL_W'(i);
        end
      end
    end else begin
      // Search ptr+1, ptr+2, ... wrapping; the first requester found wins.
      for (int k = 1; k <= N; k++) begin
        rr_idx = SEL_W'((int'(ptr) + k) % N);
        if (!grant_valid && in_valid[rr_idx]) begin
          grant_valid = 1'b1;
          grant_idx   = rr_idx;
        end
      end
    end
  end

  // Single-entry output register: it can take a word when empty or draining.
  assign load_en    = !out_valid || out_ready;
  assign xfer       = load_en && grant_valid;
  assign grant      = grant_valid ? (N'(1) << grant_idx) : '0;
  assign grant_data = in_data[grant_idx*W +: W];
  assign in_ready   = (rst_n && load_en) ? grant : '0;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
      ptr       <= SEL_W'(N - 1);
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= grant_data;
      out_chan  <= grant_idx;
      if (mode_e'(mode) == MODE_RR) begin
        ptr <= grant_idx;
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_nto1_rr.sv
// Bench for mux_nto1_rr: an 8-channel instance checked through a scoreboard
// and a 5-channel instance used for the out-of-range select case.
module tb_mux_nto1_rr;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [63:0] in_data8;
  logic [7:0]  in_valid8, in_ready8;
  logic        mode8, out_valid8, out_ready8;
  logic [2:0]  sel8, out_chan8;
  logic [7:0]  out_data8;

  logic [39:0] in_data5;
  logic [4:0]  in_valid5, in_ready5;
  logic        mode5, out_valid5, out_ready5;
  logic [2:0]  sel5, out_chan5;
  logic [7:0]  out_data5;

  mux_nto1_rr #(.N(8), .W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data8), .in_valid(in_valid8),
    .in_ready(in_ready8), .mode(mode8), .sel(sel8), .out_data(out_data8),
    .out_valid(out_valid8), .out_ready(out_ready8), .out_chan(out_chan8)
  );

  mux_nto1_rr #(.N(5), .W(8)) dut5 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data5), .in_valid(in_valid5),
    .in_ready(in_ready5), .mode(mode5), .sel(sel5), .out_data(out_data5),
    .out_valid(out_valid5), .out_ready(out_ready5), .out_chan(out_chan5)
  );

  typedef struct packed {
    logic [2:0] chan;
    logic [7:0] data;
  } word_t;

  word_t sb_q[$];
  word_t exp_w;
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every word the consumer takes must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && out_valid8 && out_ready8) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_unexpected: got chan %0d data %0h, expected no word (t=%0t)",
                 out_chan8, out_data8, $time);
      end else begin
        exp_w = sb_q.pop_front();
        check("sb_chan", 64'(out_chan8), 64'(exp_w.chan));
        check("sb_data", 64'(out_data8), 64'(exp_w.data));
      end
    end
  end

  task automatic set_data8(input logic [7:0] base);
    for (int i = 0; i < 8; i++) in_data8[i*8 +: 8] = base + 8'(i);
  endtask

  // One cycle on dut8: drive, check in_ready against the hand-computed grant,
  // and queue the word the grant should deliver.
  task automatic step(input string name, input logic [7:0] v, input logic m,
                      input logic [2:0] s, input logic ordy, input logic [7:0] exp_rdy);
    word_t w;
    in_valid8  = v;
    mode8      = m;
    sel8       = s;
    out_ready8 = ordy;
    @(negedge clk);
    check(name, 64'(in_ready8), 64'(exp_rdy));
    for (int i = 0; i < 8; i++) begin
      if (exp_rdy[i]) begin
        w.chan = 3'(i);
        w.data = in_data8[i*8 +: 8];
        sb_q.push_back(w);
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    in_valid8 = 8'hFF; mode8 = 1'b1; sel8 = '0; out_ready8 = 1'b1;
    set_data8(8'h00);
    in_valid5 = '0; mode5 = 1'b0; sel5 = '0; out_ready5 = 1'b1;
    for (int i = 0; i < 5; i++) in_data5[i*8 +: 8] = 8'hE0 + 8'(i);

    // Reset with every channel requesting.
    @(negedge clk);
    check("rst_out_valid", 64'(out_valid8), 64'd0);
    check("rst_in_ready",  64'(in_ready8),  64'd0);
    check("rst_out_data",  64'(out_data8),  64'd0);
    check("rst_out_chan",  64'(out_chan8),  64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Fixed select of channel 3; leaves the pointer at N-1.
    set_data8(8'hA0);
    in_data8[3*8 +: 8] = 8'hA5;
    step("fix_sel3_ready", 8'hFF, 1'b0, 3'd3, 1'b1, 8'h08);
    step("idle_ready", 8'h00, 1'b1, 3'd0, 1'b1, 8'h00);
    check("drain_out_valid", 64'(out_valid8), 64'd0);

    // Round-robin, all valid: 0,1,...,7,0 at one word per cycle.
    for (int k = 0; k < 9; k++) begin
      set_data8(8'(k * 16));
      step("rr_all_ready", 8'hFF, 1'b1, 3'd0, 1'b1, 8'(1 << (k % 8)));
    end
    step("idle_ready", 8'h00, 1'b1, 3'd0, 1'b1, 8'h00);

    // Only ch2 and ch6 request: 2,6,2,6 including the wrap from 6 to 2.
    for (int k = 0; k < 4; k++) begin
      set_data8(8'hC0 + 8'(k * 8));
      step("rr_skip_ready", 8'h44, 1'b1, 3'd0, 1'b1, (k % 2) ? 8'h40 : 8'h04);
    end
    step("idle_ready", 8'h00, 1'b1, 3'd0, 1'b1, 8'h00);

    // Back-pressure: ch0 word (0x50) held for 5 cycles while inputs churn.
    set_data8(8'h50);
    step("bp_load_ready", 8'h01, 1'b1, 3'd0, 1'b1, 8'h01);
    for (int k = 0; k < 5; k++) begin
      set_data8(8'h60 + 8'(k * 8));
      in_valid8 = 8'hFF; mode8 = k[0]; sel8 = 3'(k); out_ready8 = 1'b0;
      @(negedge clk);
      check("bp_in_ready",  64'(in_ready8),  64'd0);
      check("bp_out_valid", 64'(out_valid8), 64'd1);
      check("bp_out_data",  64'(out_data8),  64'h50);
      check("bp_out_chan",  64'(out_chan8),  64'd0);
      @(posedge clk);
      #1;
    end
    set_data8(8'h70);
    step("bp_release_ready", 8'hFF, 1'b1, 3'd0, 1'b1, 8'h02);
    in_valid8 = 8'h00;
    @(negedge clk);
    check("bp_valid_kept", 64'(out_valid8), 64'd1);
    @(posedge clk);
    #1;

    // N=5: sel 6 is out of range, nothing granted.
    in_valid5 = 5'h1F; mode5 = 1'b0; sel5 = 3'd6; out_ready5 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("n5_sel6_ready", 64'(in_ready5),  64'd0);
      check("n5_sel6_valid", 64'(out_valid5), 64'd0);
      @(posedge clk);
      #1;
    end
    sel5 = 3'd4;
    @(negedge clk);
    check("n5_sel4_ready", 64'(in_ready5), 64'h10);
    @(posedge clk);
    #1;
    in_valid5 = '0; out_ready5 = 1'b0;
    @(negedge clk);
    check("n5_out_valid", 64'(out_valid5), 64'd1);
    check("n5_out_chan",  64'(out_chan5),  64'd4);
    check("n5_out_data",  64'(out_data5),  64'hE4);
    @(posedge clk);
    #1;

    // Reset mid-stream with words held in both instances.
    set_data8(8'h30);
    step("pre_rst_ready", 8'hFF, 1'b1, 3'd0, 1'b0, 8'h04);
    #3;
    check("pre_rst_valid", 64'(out_valid8), 64'd1);
    rst_n = 1'b0;
    #1;
    check("async_rst_valid8", 64'(out_valid8), 64'd0);
    check("async_rst_valid5", 64'(out_valid5), 64'd0);
    check("async_rst_ready",  64'(in_ready8),  64'd0);
    sb_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    set_data8(8'h40);
    step("post_rst_rr_ready", 8'hFF, 1'b1, 3'd0, 1'b1, 8'h01);
    step("idle_ready", 8'h00, 1'b1, 3'd0, 1'b1, 8'h00);
    step("idle_ready", 8'h00, 1'b1, 3'd0, 1'b1, 8'h00);
    check("sb_drained", 64'(sb_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
